// File: rtl/video_pattern_gen.sv
// RGB565 test-pattern raster source: bars, grey ramp, checkerboard, solid.
// Pattern select is captured at frame start so a frame never mixes patterns.
module video_pattern_gen #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int H_TOTAL    = 2048,
    parameter int V_TOTAL    = 1085,
    parameter int CHECK_LOG2 = 6
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode_sel,
    input  logic [15:0] solid_color,
    output logic        video_clk,
    output logic        video_rst,
    output logic        video_de,
    output logic [15:0] video_data,
    output logic [7:0]  frame_cnt
);

    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);
    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [7:0]    r_frame;
    logic [1:0]    r_mode;
    logic [15:0]   r_solid;
    logic          r_de;
    logic          r_vrst;
    logic [15:0]   r_data;

    logic          w_frame_start;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_active;
    logic [1:0]    w_mode;
    logic [15:0]   w_solid;
    logic [2:0]    w_bar;
    logic [5:0]    w_g6;
    logic          w_chk;
    logic [15:0]   w_bar_rgb;
    logic [15:0]   w_pix;

    assign video_clk  = sys_clk;
    assign video_rst  = r_vrst;
    assign video_de   = r_de;
    assign video_data = r_data;
    assign frame_cnt  = r_frame;

    always_comb begin
        w_frame_start = en && (r_h == '0) && (r_v == '0);
        w_h_last      = (r_h == H_LAST);
        w_v_last      = (r_v == V_LAST);
        w_active      = en && (r_h < H_ACT) && (r_v < V_ACT);
        // The first pixel of a frame must already use the new selection.
        w_mode        = w_frame_start ? mode_sel : r_mode;
        w_solid       = w_frame_start ? solid_color : r_solid;
        w_bar         = 3'(32'(r_h) / BAR_W);
        w_g6          = 6'(r_h >> 2);
        w_chk         = r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2] ^ r_frame[0];
    end

    always_comb begin
        w_bar_rgb = 16'h0000;
        case (w_bar)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'hF81F;
            3'd3:    w_bar_rgb = 16'hF800;
            3'd4:    w_bar_rgb = 16'h07FF;
            3'd5:    w_bar_rgb = 16'h07E0;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end

    always_comb begin
        w_pix = 16'h0000;
        case (w_mode)
            2'd0:    w_pix = w_bar_rgb;
            2'd1:    w_pix = {w_g6[5:1], w_g6, w_g6[5:1]};
            2'd2:    w_pix = w_chk ? 16'hFFFF : 16'h0000;
            default: w_pix = w_solid;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_h     <= '0;
            r_v     <= '0;
            r_frame <= '0;
            r_mode  <= '0;
            r_solid <= '0;
            r_de    <= 1'b0;
            r_vrst  <= 1'b0;
            r_data  <= '0;
        end else begin
            if (!en) begin
                r_h <= '0;
                r_v <= '0;
            end else begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
                if (w_h_last && w_v_last) begin
                    r_frame <= r_frame + 1'b1;
                end
                if (w_frame_start) begin
                    r_mode  <= mode_sel;
                    r_solid <= solid_color;
                end
            end
            r_de   <= w_active;
            r_vrst <= en && w_v_last;
            r_data <= w_active ? w_pix : 16'h0000;
        end
    end

endmodule
